// File: rtl/tmul_bi_vec_if.sv
// Operand/result bundle for tmul_bi_vec.
// The master side offers operands and observes the product stream;
// the slave side is the multiplier itself.
interface tmul_bi_vec_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      iA;
  logic [CH*WIDTH-1:0]   iB;
  logic                  abort;
  logic                  out_valid;
  logic [CH-1:0]         oC;
  logic                  last;
  logic                  busy;

  modport master (
    output in_valid, iA, iB, abort,
    input  in_ready, out_valid, oC, last, busy
  );

  modport slave (
    input  in_valid, iA, iB, abort,
    output in_ready, out_valid, oC, last, busy
  );
endinterface

// File: rtl/tmul_bi_vec.sv
// Multi-channel temporal-coded bipolar unary multiplier.
// Operand A is shared by all CH channels and is coded as a run length over a
// 2^WIDTH-cycle window; each channel's B is compared against a bit-reversed
// counter (Sobol dim-1). One product bit per channel per valid cycle.
// Optional macro TMUL_BI_VEC_ACC_EN adds per-channel signed accumulators
// (acc / acc_valid) that sum +1/-1 over each completed window.
module tmul_bi_vec #(
  parameter int WIDTH = 8,
  parameter int CH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  tmul_bi_vec_if.slave     bus
`ifdef TMUL_BI_VEC_ACC_EN
  ,
  output logic [CH*(WIDTH+2)-1:0] acc,
  output logic                    acc_valid
`endif
);

  localparam logic [WIDTH-1:0] K_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [WIDTH-1:0]      k, k_next;
  logic [WIDTH-1:0]      a_q;
  logic [CH*WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]      rng;
  logic [CH-1:0]         cmp;
  logic [CH-1:0]         oc;
  logic                  accept;

  assign accept = (state == IDLE) && bus.in_valid;

  // State register; reset drops straight back to IDLE, discarding any window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and window counter; abort wins over the final-bit transition.
  always_comb begin
    state_next = state;
    k_next     = k;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
          k_next     = '0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
          k_next     = '0;
        end else if (k == K_LAST) begin
          state_next = DONE;
          k_next     = '0;
        end else begin
          k_next = k + WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        k_next     = '0;
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
      end
    endcase
  end

  // Counter and operand buffers; operands are captured only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k   <= '0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      k <= k_next;
      if (accept) begin
        a_q <= bus.iA;
        b_q <= bus.iB;
      end
    end
  end

  // Product bits: B vs bit-reversed k, inverted once k has passed A's run.
  always_comb begin
    rng = '0;
    cmp = '0;
    oc  = '0;
    for (int j = 0; j < WIDTH; j++) rng[j] = k[WIDTH-1-j];
    for (int i = 0; i < CH; i++) begin
      cmp[i] = (b_q[i*WIDTH +: WIDTH] > rng);
      if (state == RUN) oc[i] = (k < a_q) ? cmp[i] : ~cmp[i];
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == RUN);
  assign bus.busy      = (state != IDLE);
  assign bus.last      = (state == RUN) && (k == K_LAST);
  assign bus.oC        = oc;

`ifdef TMUL_BI_VEC_ACC_EN
  localparam logic signed [WIDTH+1:0] ACC_UP   = (WIDTH+2)'(1);
  localparam logic signed [WIDTH+1:0] ACC_DOWN = -(WIDTH+2)'(1);

  logic signed [WIDTH+1:0] acc_q [CH];

  // Bipolar running sums: cleared on accept or abort, +1/-1 per valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
    end else if ((state != IDLE) && bus.abort) begin
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < CH; i++) acc_q[i] <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < CH; i++)
        acc_q[i] <= acc_q[i] + (oc[i] ? ACC_UP : ACC_DOWN);
    end
  end

  // Flatten the channel sums onto the output bus.
  always_comb begin
    acc = '0;
    for (int i = 0; i < CH; i++) acc[i*(WIDTH+2) +: (WIDTH+2)] = acc_q[i];
  end

  assign acc_valid = (state == DONE);
`endif

endmodule

// File: tb/tb_tmul_bi_vec.sv
// Directed testbench for tmul_bi_vec (WIDTH=8, CH=4).
// Define TMUL_BI_VEC_ACC_EN to also check the accumulator outputs.
module tb_tmul_bi_vec;

  localparam int WIDTH = 8;
  localparam int CH    = 4;
  localparam int WIN   = 256;
  localparam int AW    = WIDTH + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tmul_bi_vec_if #(.WIDTH(WIDTH), .CH(CH)) bus ();

`ifdef TMUL_BI_VEC_ACC_EN
  logic [CH*AW-1:0] acc;
  logic             acc_valid;
`endif

  tmul_bi_vec #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef TMUL_BI_VEC_ACC_EN
    ,
    .acc       (acc),
    .acc_valid (acc_valid)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  int ones [CH];
  int validCycles;
  int lastCount;
  int lastIdx;
  int modelErrs;
  logic            accValidSeen;
  logic [CH*AW-1:0] accSeen;

  // One comparison: counted, asserted, reported with tag/observed/expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    end
  endtask

  // Independent reference for one product bit.
  function automatic logic refBit(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] k);
    logic [7:0] r;
    logic       c;
    for (int j = 0; j < 8; j++) r[j] = k[7-j];
    c = (b > r);
    return (k < a) ? c : ~c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [31:0] b);
    bus.iA       = a;
    bus.iB       = b;
    bus.in_valid = 1'b1;
  endtask

  // Accept one operand set and observe the full window plus the DONE cycle.
  task automatic runWindow(input logic [7:0] a, input logic [31:0] b);
    int k;
    applyStimulus(a, b);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < CH; i++) ones[i] = 0;
    lastCount    = 0;
    lastIdx      = -1;
    modelErrs    = 0;
    accValidSeen = 1'b0;
    accSeen      = '0;
    k = 0;
    while (bus.out_valid === 1'b1 && k < 300) begin
      for (int i = 0; i < CH; i++) begin
        ones[i] += int'(bus.oC[i]);
        if (bus.oC[i] !== refBit(a, b[i*8 +: 8], 8'(k))) modelErrs++;
      end
      if (bus.last === 1'b1) begin
        lastCount++;
        lastIdx = k;
      end
      k++;
      step();
    end
    validCycles = k;
`ifdef TMUL_BI_VEC_ACC_EN
    accValidSeen = acc_valid;
    accSeen      = acc;
`endif
    step();
  endtask

  task automatic drainIdle(input string tag);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 300) begin
      step();
      n++;
    end
    checkOutput(tag, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gap;
    int lastsSeen;
    logic rdy;

    bus.in_valid = 1'b0;
    bus.iA       = '0;
    bus.iB       = '0;
    bus.abort    = 1'b0;

    // Reset and idle
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    checkOutput("idle_in_ready",  {31'b0, bus.in_ready},  32'd1);
    checkOutput("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("idle_oC",        {28'b0, bus.oC},        32'd0);
    checkOutput("idle_busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("idle_last",      {31'b0, bus.last},      32'd0);

    // A=255, B={255,0,128,1}
    runWindow(8'd255, 32'h01_80_00_FF);
    checkOutput("w1_valid_cycles", validCycles, WIN);
    checkOutput("w1_last_count",   lastCount,   1);
    checkOutput("w1_last_idx",     lastIdx,     WIN-1);
    checkOutput("w1_ones0",        ones[0],     256);
    checkOutput("w1_ones1",        ones[1],     1);
    checkOutput("w1_ones2",        ones[2],     129);
    checkOutput("w1_ones3",        ones[3],     2);
    checkOutput("w1_model",        modelErrs,   0);
`ifdef TMUL_BI_VEC_ACC_EN
    checkOutput("w1_acc_valid", {31'b0, accValidSeen}, 32'd1);
    checkOutput("w1_acc0", 32'($signed(accSeen[0*AW +: AW])), 256);
    checkOutput("w1_acc1", 32'($signed(accSeen[1*AW +: AW])), -254);
    checkOutput("w1_acc2", 32'($signed(accSeen[2*AW +: AW])), 2);
    checkOutput("w1_acc3", 32'($signed(accSeen[3*AW +: AW])), -252);
`endif
    checkOutput("w1_back_idle", {31'b0, bus.in_ready}, 32'd1);

    // A=128, B={128,0,255,64}
    runWindow(8'd128, 32'h40_FF_00_80);
    checkOutput("w2_valid_cycles", validCycles, WIN);
    checkOutput("w2_ones0",        ones[0],     128);
    checkOutput("w2_ones1",        ones[1],     128);
    checkOutput("w2_ones2",        ones[2],     129);
    checkOutput("w2_ones3",        ones[3],     128);
    checkOutput("w2_model",        modelErrs,   0);

    // A=0, B=0 with in_valid held high: back-to-back accept spacing
    applyStimulus(8'd0, 32'h0);
    step();
    applyStimulus(8'd200, 32'h11_22_33_44);
    for (int i = 0; i < CH; i++) ones[i] = 0;
    gap = -1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      rdy = bus.in_ready;
      if (bus.out_valid === 1'b1)
        for (int i = 0; i < CH; i++) ones[i] += int'(bus.oC[i]);
      step();
      if (rdy === 1'b1) begin
        gap = cyc;
        break;
      end
    end
    bus.in_valid = 1'b0;
    checkOutput("b2b_gap",   gap,     WIN + 2);
    checkOutput("b2b_ones0", ones[0], 256);
    checkOutput("b2b_ones1", ones[1], 256);
    checkOutput("b2b_ones2", ones[2], 256);
    checkOutput("b2b_ones3", ones[3], 256);
    drainIdle("b2b_drain");

    // Abort at k=100
    applyStimulus(8'd255, 32'h01_80_00_FF);
    step();
    bus.in_valid = 1'b0;
    lastsSeen = 0;
    for (int i = 0; i < 100; i++) begin
      lastsSeen += int'(bus.last);
      step();
    end
    checkOutput("abort_pre_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    checkOutput("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("abort_last",      {31'b0, bus.last},      32'd0);
    checkOutput("abort_busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("abort_no_last",   lastsSeen,              0);
`ifdef TMUL_BI_VEC_ACC_EN
    checkOutput("abort_acc_valid", {31'b0, acc_valid}, 32'd0);
    checkOutput("abort_acc_clear", {22'b0, acc[AW-1:0]}, 32'd0);
`endif
    step();
    checkOutput("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    runWindow(8'd255, 32'h01_80_00_FF);
    checkOutput("post_abort_cycles", validCycles, WIN);
    checkOutput("post_abort_ones2",  ones[2],     129);
    checkOutput("post_abort_model",  modelErrs,   0);

    // abort in IDLE must not block an accept
    applyStimulus(8'd10, 32'h0);
    bus.abort = 1'b1;
    step();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("idle_abort_ignored", {31'b0, bus.out_valid}, 32'd1);
    drainIdle("idle_abort_drain");

    // Reset asserted at k=50
    applyStimulus(8'd128, 32'h40_FF_00_80);
    step();
    bus.in_valid = 1'b0;
    repeat (50) step();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    checkOutput("rst_busy",      {31'b0, bus.busy},      32'd0);
    checkOutput("rst_oC",        {28'b0, bus.oC},        32'd0);
    checkOutput("rst_last",      {31'b0, bus.last},      32'd0);
    checkOutput("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    runWindow(8'd128, 32'h40_FF_00_80);
    checkOutput("post_rst_cycles", validCycles, WIN);
    checkOutput("post_rst_ones0",  ones[0],     128);
    checkOutput("post_rst_ones2",  ones[2],     129);
    checkOutput("post_rst_ones3",  ones[3],     128);
    checkOutput("post_rst_model",  modelErrs,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
